// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared widths, ALU op codes, instruction fields and sequencer states
package alu_sequencer_pkg;

  localparam int SEQ_DATA_W     = 8;
  localparam int SEQ_REG_ADDR_W = 2;
  localparam int SEQ_INSTR_W    = 4 + 2 * SEQ_REG_ADDR_W + SEQ_DATA_W;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Field LSB positions: [op | imm_sel | rd | rs | imm8 or rt in the top bits of imm8]
  localparam int F_OP_LSB  = SEQ_INSTR_W - 3;
  localparam int F_IMM_SEL = SEQ_INSTR_W - 4;
  localparam int F_RD_LSB  = F_IMM_SEL - SEQ_REG_ADDR_W;
  localparam int F_RS_LSB  = F_RD_LSB - SEQ_REG_ADDR_W;
  localparam int F_RT_LSB  = SEQ_DATA_W - SEQ_REG_ADDR_W;
  localparam int F_IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction handshake, ALU side and status bundle of the sequencer
interface alu_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 16
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic [DATA_W-1:0]  alu_a;
  logic [DATA_W-1:0]  alu_b;
  logic [2:0]         alu_code;
  logic [DATA_W-1:0]  alu_y;
  logic               alu_carry;
  logic               alu_zero;
  logic               done;
  logic [DATA_W-1:0]  result;
  logic               flag_c;
  logic               flag_z;

  modport master (
    output in_valid, in_instr, alu_y, alu_carry, alu_zero,
    input  in_ready, alu_a, alu_b, alu_code, done, result, flag_c, flag_z
  );

  modport slave (
    input  in_valid, in_instr, alu_y, alu_carry, alu_zero,
    output in_ready, alu_a, alu_b, alu_code, done, result, flag_c, flag_z
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - seq_regfile: 2**ADDR_W x DATA_W, two async reads, one sync write
// Optional debug read port under SEQ_DEBUG_EN.
module seq_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
`ifdef SEQ_DEBUG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

`ifdef SEQ_DEBUG_EN
  assign dbg_rdata = mem[dbg_addr];
`endif
endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues one instruction at a time to an 8-bit ALU and writes back its result
// SEQ_DEBUG_EN adds dbg_sel/dbg_data, a combinational register peek.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W     = SEQ_DATA_W,
  parameter int REG_ADDR_W = SEQ_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_sequencer_if.slave        bus
`ifdef SEQ_DEBUG_EN
  ,
  input  logic [REG_ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
`endif
);
  seq_state_t state, next_state;

  logic [REG_ADDR_W-1:0] rs, rt, rd_in, rd_q;
  logic [DATA_W-1:0]     rs_data, rt_data, imm;
  logic                  imm_sel;
  logic                  accept;
  logic                  write_back;

  assign rs      = bus.in_instr[F_RS_LSB +: REG_ADDR_W];
  assign rt      = bus.in_instr[F_RT_LSB +: REG_ADDR_W];
  assign rd_in   = bus.in_instr[F_RD_LSB +: REG_ADDR_W];
  assign imm     = bus.in_instr[F_IMM_LSB +: DATA_W];
  assign imm_sel = bus.in_instr[F_IMM_SEL];

  assign accept     = (state == S_IDLE) && bus.in_valid;
  assign write_back = (state == S_ISSUE);

  seq_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (write_back),
    .waddr     (rd_q),
    .wdata     (bus.alu_y),
    .raddr_a   (rs),
    .rdata_a   (rs_data),
    .raddr_b   (rt),
    .rdata_b   (rt_data)
`ifdef SEQ_DEBUG_EN
    ,
    .dbg_addr  (dbg_sel),
    .dbg_rdata (dbg_data)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.in_valid) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WB;
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.in_ready = (state == S_IDLE);
  assign bus.done     = (state == S_WB);

  // Operands are captured at accept so the instruction bus is free during S_ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_code <= OP_ADD;
      rd_q         <= '0;
    end else if (accept) begin
      bus.alu_a    <= rs_data;
      bus.alu_b    <= imm_sel ? imm : rt_data;
      bus.alu_code <= bus.in_instr[F_OP_LSB +: 3];
      rd_q         <= rd_in;
    end
  end

  // Carry is architecturally meaningful only for ADD; other ops leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result <= '0;
      bus.flag_c <= 1'b0;
      bus.flag_z <= 1'b0;
    end else if (write_back) begin
      bus.result <= bus.alu_y;
      bus.flag_z <= bus.alu_zero;
      if (bus.alu_code == OP_ADD) bus.flag_c <= bus.alu_carry;
    end
  end
endmodule
